// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM controller: FSM encoding, command fields,
// DPU modifier codes and default geometry.
package sram_pkg;

  localparam int unsigned DefAw = 5;
  localparam int unsigned DefDw = 32;

  localparam int unsigned CmdDpuBit = 7;
  localparam int unsigned CmdOpBit  = 6;
  localparam int unsigned CmdModHi  = 6;
  localparam int unsigned CmdModLo  = 5;
  localparam int unsigned CmdAddrLo = 0;

  typedef enum logic [2:0] {
    StIdle,
    StDRdReq,
    StDRdRsp,
    StDWr,
    StHRdRsp
  } state_e;

  typedef enum logic [1:0] {
    ModAdd = 2'd0,
    ModSub = 2'd1,
    ModMul = 2'd2,
    ModDiv = 2'd3
  } mod_e;

  function automatic mod_e cmd_mod(input logic [7:0] cmd);
    return mod_e'(cmd[CmdModHi:CmdModLo]);
  endfunction

endpackage

// File: rtl/sram_32x32.sv
// Single-port synchronous SRAM with a registered, async-reset read output that
// holds its value while no read is enabled.
module sram_32x32
  import sram_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned DW = DefDw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned Depth = 1 << AW;

  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_ctrl.sv
// SRAM controller: serves direct host reads/writes and arbitrates the DPU
// read-modify-write handshake against a 32x32 synchronous memory.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned DW = DefDw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  input  logic [7:0]    cmd,
  input  logic [DW-1:0] wdata,
  output logic          cmd_ready,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          dpu_load_cmd,
  output logic [7:0]    nxt_cmd,
  output logic          requst_valid,
  output logic [DW-1:0] sram_data_read,
  input  logic          read_requst,
  input  logic          send_request,
  input  logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_data_out
);

  state_e state_q, state_d;

  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    rdata_valid  = 1'b0;
    dpu_load_cmd = 1'b0;
    nxt_cmd      = '0;
    requst_valid = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd[CmdDpuBit]) begin
            dpu_load_cmd = 1'b1;
            nxt_cmd      = cmd;
            state_d      = StDRdReq;
          end else if (cmd[CmdOpBit]) begin
            mem_we    = 1'b1;
            mem_addr  = cmd[CmdAddrLo +: AW];
            mem_wdata = wdata;
          end else begin
            mem_re   = 1'b1;
            mem_addr = cmd[CmdAddrLo +: AW];
            state_d  = StHRdRsp;
          end
        end
      end
      StHRdRsp: begin
        rdata_valid = 1'b1;
        state_d     = StIdle;
      end
      StDRdReq: begin
        if (read_requst) begin
          mem_re   = 1'b1;
          mem_addr = sram_addr;
          state_d  = StDRdRsp;
        end
      end
      StDRdRsp: begin
        requst_valid = 1'b1;
        state_d      = StDWr;
      end
      StDWr: begin
        // The DPU's result is already registered here, so grant and write together.
        if (send_request) begin
          requst_valid = 1'b1;
          mem_we       = 1'b1;
          mem_addr     = sram_addr;
          mem_wdata    = sram_data_out;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  sram_32x32 #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign rdata          = mem_rdata;
  assign sram_data_read = mem_rdata;

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

SRAM controller and responder for the DPU request/valid protocol. It owns a 32-word x 32-bit synchronous memory and accepts 8-bit host commands. It serves direct host reads and writes itself, and hands read-modify-write commands (cmd[7]=1) to the DPU. It then answers the DPU's read request and send request with single-cycle `requst_valid` pulses.

## Interface
Parameters:
- `AW`, 5: address width; depth = 2^AW = 32 words.
- `DW`, 32: data width.

Ports (reset is asynchronous, active-low `rst_n`; clock is `clk`):
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `cmd_valid` input 1: host command present.
- `cmd` input 8: [7] DPU op; [6:5] DPU mod or direct op; [4:0] address.
- `wdata` input DW: host write data.
- `cmd_ready` output 1: command accepted this cycle when `cmd_valid & cmd_ready`.
- `rdata` output DW: host read data.
- `rdata_valid` output 1: one-cycle pulse, `rdata` valid.
- `dpu_load_cmd` output 1: DPU latches `nxt_cmd`.
- `nxt_cmd` output 8: command to DPU.
- `requst_valid` output 1: one-cycle grant to DPU read/send request.
- `sram_data_read` output DW: memory read data to DPU.
- `read_requst` input 1: DPU read request.
- `send_request` input 1: DPU write-back request.
- `sram_addr` input AW: DPU target address.
- `sram_data_out` input DW: DPU result.

## Operation
- Direct commands (cmd[7]=0):
  - cmd[6]=1 is a write: mem[cmd[4:0]] <= wdata.
  - cmd[6]=0 is a read.
  - cmd[5] is reserved and ignored.
- FSM states: IDLE, D_RDREQ, D_RDRSP, D_WR, H_RDRSP.
- IDLE:
  - `cmd_ready` = 1.
  - On accept with cmd[7]=1: `dpu_load_cmd` = 1, `nxt_cmd` = cmd, go to D_RDREQ.
  - Direct read: issue memory read, go to H_RDRSP.
  - Direct write: write memory, stay in IDLE.
- H_RDRSP: `rdata_valid` = 1, `rdata` = memory output, go to IDLE.
- D_RDREQ: wait for `read_requst`. When it is high, issue memory read at `sram_addr` and go to D_RDRSP.
- D_RDRSP: `requst_valid` = 1, `sram_data_read` = memory output, go to D_WR.
- D_WR: wait for `send_request`. When it is high: `requst_valid` = 1, mem[sram_addr] <= sram_data_out, go to IDLE.
- `requst_valid` is combinational: (state==D_RDRSP) | (state==D_WR & send_request).
- `dpu_load_cmd` = IDLE & cmd_valid & cmd[7].
- `nxt_cmd` = cmd when `dpu_load_cmd` is high, else 0.
- `cmd_ready` = 0 in every state except IDLE.
- DPU requests arriving outside their wait state are ignored: no grant, no memory access.
- `rdata` and `sram_data_read` hold the last memory read value until the next read.
- Memory contents are not reset.

## Timing
- Reset values:
  - `cmd_ready` = 1 (FSM in IDLE).
  - `rdata_valid`, `dpu_load_cmd`, `requst_valid` = 0.
  - `nxt_cmd` = 0.
  - `rdata`, `sram_data_read` = 0 (memory output register cleared).
- Host write: accepted in cycle 0, visible to a read accepted in cycle 1.
- Host read: accepted in cycle 0; `rdata_valid` in cycle 1; next command accepted in cycle 2.
- DPU op, cycle by cycle (accept = cycle 0):
  - cycle 1: `read_requst` seen.
  - cycle 2: `requst_valid` with data.
  - cycle 3: DPU computes.
  - cycle 4: `send_request` granted and memory written.
  - cycle 5: IDLE, next command accepted.
- The DPU's registered result is valid in its send state. The controller writes on the same cycle it grants.
- `rst_n` asserted mid-operation: FSM returns to IDLE immediately and no write is issued. Any write already clocked stays. The DPU resets from the same `rst_n`.

## Structure
- Shared package `sram_pkg`:
  - FSM state encoding.
  - cmd field positions: DPU bit, mod, op, addr.
  - mod codes ADD/SUB/MUL/DIV.
  - AW/DW defaults.
- Sub-module `sram_32x32`: one synchronous read/write port, output register with async reset, read enable holds output.

## Test plan
- Write `0x0000_0010` to addr 3 (cmd `0x43`), then read (cmd `0x03`) -> `rdata_valid` pulse with `rdata` = `0x0000_0010`, one cycle after accept.
- With a DPU attached, addr 3 = `0x10`, cmd `0x83` (ADD) -> `requst_valid` in cycles 2 and 4, mem[3] = `0x11`, `cmd_ready` back high at cycle 5.
- addr 0 = `0`, cmd `0xA0` (SUB) -> mem[0] = `0xFFFF_FFFF` (wrap). Then cmd `0xE0` (DIV) -> `0x7FFF_FFFF`.
- cmd `0xC7` (MUL) on `0x8000_0001` -> mem[7] = `0x0000_0002`. A host command held valid during the op is accepted only at cycle 5.
- Inject `send_request` while in D_RDREQ -> no `requst_valid`, memory unchanged.
- Assert `rst_n` low in cycle 3 of a DPU op -> outputs at reset values, mem[addr] unchanged, and a fresh ADD afterwards completes normally.
